offset_cal_10b: RTL
===================

Name: offset_cal_10b

Overview:
- Foreground offset-calibration engine for the 10-bit ADC path.
- While the ADC inputs are shorted, it averages a block of raw 10-bit codes and computes the signed correction, i.e. ideal mid-code minus measured mean.
- It drives the 12-bit sign-extended `osc` word consumed directly downstream by the offset-correction adder, which uses `osc[9:0]` as a signed 10-bit value.
- The FSM controls calibration; `osc` holds its last value between calibrations.

Parameters:
- LOG2_N, 6, log2 of the number of averaged samples (N = 64); legal range 1..8.
- SETTLE, 4, number of valid samples discarded after `cal_start` before accumulation; 0 is legal.
- MID_CODE, 512, ideal code with inputs shorted (unsigned 10-bit).

Ports:
- `clk`, input, 1, system clock; all logic rising-edge.
- `rst`, input, 1, asynchronous active-high reset.
- `cal_start`, input, 1, single-cycle request to start calibration; ignored unless the FSM is in IDLE.
- `adc_valid`, input, 1, qualifies `adc_code` this cycle.
- `adc_code`, input, 10, raw unsigned ADC code (zero-extended by the downstream stage).
- `cal_busy`, output, 1, high in every state except IDLE.
- `cal_done`, output, 1, one-cycle pulse when `osc` updates.
- `cal_err`, output, 1, sticky: computed offset saturated; cleared by the next `cal_start` accepted in IDLE.
- `osc`, output, 12, offset correction: `{{2{off[9]}}, off[9:0]}`, two's complement.

Behaviour:
- Reset: async assert forces state IDLE, `osc = 12'h000`, `cal_busy = 0`, `cal_done = 0`, `cal_err = 0`, and clears the accumulator and counters. Reset mid-calibration aborts it; `osc` returns to 0 and no `cal_done` is issued.
- States: IDLE, SETTLE, ACCUM, COMPUTE. All outputs are registered.
- IDLE:
  - `cal_start = 1` → clear `cal_err`, accumulator and sample counter.
  - Next state is SETTLE if SETTLE > 0, else ACCUM.
- SETTLE: count valid samples; after the SETTLE-th valid sample, go to ACCUM. Invalid cycles do not count.
- ACCUM:
  - On each `adc_valid`, `acc += adc_code`.
  - `acc` width is 10 + LOG2_N bits (16 by default); it never overflows.
  - After the N-th valid sample is added (same edge), go to COMPUTE.
- COMPUTE: one cycle, combinational math registered at the exit edge.
  - `mean = (acc + 2^(LOG2_N-1)) >> LOG2_N`, i.e. round-half-up, range 0..1023.
  - `diff = MID_CODE - mean`, computed at 11-bit signed.
  - Saturate `diff` to [-512, +511] → `off[9:0]`. If clamped, set `cal_err = 1`.
  - At the COMPUTE→IDLE edge: `osc` updates, `cal_done = 1` for exactly one cycle, `cal_busy` falls.
- Latency: from the `cal_start` edge, `cal_done` rises SETTLE + N valid samples + 2 cycles later. With `adc_valid` constantly high and defaults, that is 70 cycles.
- `cal_start` asserted while busy (including the COMPUTE cycle): ignored, with no restart and no queueing.
- `cal_start` in the same cycle that `cal_done` is high (FSM already IDLE): accepted.
- `adc_valid` while IDLE: ignored.
- `osc` holds its old value throughout a calibration; it never shows partial results.

Decomposition:
- Shared include/package `offset_cal_defs`:
  - state encodings (IDLE = 2'd0, SETTLE = 2'd1, ACCUM = 2'd2, COMPUTE = 2'd3);
  - ADC_W = 10;
  - OSC_W = 12;
  - saturation limits OFF_MAX = 511 and OFF_MIN = -512.
- One sub-module `offset_cal_math`: purely combinational `acc` → rounded mean → subtract → saturate → sign-extend to 12 bits, plus a `sat` flag. It is unit-testable in isolation.
- FSM, counters and output registers live in `offset_cal_10b`.

Test Plan:
- Reset, then `cal_start`, `adc_valid` = 1, all codes 512 → `cal_done` pulse at cycle 70; `osc = 12'h000`, `cal_err = 0`.
- All codes 520 → `osc = 12'hFF8` (−8); all codes 500 → `osc = 12'h00C` (+12).
- Rounding: 32×510 then 32×511 (acc = 32672) → mean 511 → `osc = 12'h001`.
- Saturation:
  - all codes 0 → `osc = 12'h1FF`, `cal_err = 1`;
  - a following calibration with codes 512 → `cal_err` cleared at start, `osc = 12'h000`.
- Settle and gaps:
  - first 4 valid samples = 1023, then 64 × 512 → `osc = 12'h000`;
  - repeat with `adc_valid` toggling every other cycle → same result, `cal_done` at cycle 138.
- Control corner cases:
  - after a calibration leaving `osc = 12'hFF8`, a second `cal_start` pulsed mid-ACCUM → ignored, single `cal_done`;
  - `rst` asserted mid-ACCUM → `osc = 12'h000`, IDLE, no `cal_done`.

Source files
------------

// File: rtl/offset_cal_defs.sv
// Shared definitions for the 10-bit ADC offset-calibration engine:
// FSM encodings, datapath widths and saturation limits.
package offset_cal_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_COMPUTE = 2'd3
  } cal_state_e;

  localparam int ADC_W   = 10;
  localparam int OSC_W   = 12;
  localparam int OFF_MAX = 511;
  localparam int OFF_MIN = -512;

  // Sign-extend a 10-bit two's-complement offset to the downstream word width.
  function automatic logic [OSC_W-1:0] sext_off(input logic [ADC_W-1:0] off);
    return {{(OSC_W - ADC_W){off[ADC_W-1]}}, off};
  endfunction

endpackage

// File: rtl/offset_cal_math.sv
// Combinational offset math: accumulator -> rounded mean -> (MID_CODE - mean)
// -> saturation to a signed 10-bit range -> 12-bit sign-extended correction.
module offset_cal_math
  import offset_cal_defs::*;
#(
  parameter int LOG2_N   = 6,
  parameter int MID_CODE = 512
) (
  input  logic [ADC_W+LOG2_N-1:0] acc,
  output logic [OSC_W-1:0]        osc,
  output logic                    sat
);

  localparam int ACC_W = ADC_W + LOG2_N;
  localparam int DIF_W = ACC_W + 2;

  localparam logic [ACC_W:0]              HALF  = (ACC_W + 1)'(2 ** (LOG2_N - 1));
  localparam logic signed [DIF_W-1:0]     MID_S = DIF_W'(MID_CODE);
  localparam logic signed [DIF_W-1:0]     MAX_S = DIF_W'(OFF_MAX);
  localparam logic signed [DIF_W-1:0]     MIN_S = DIF_W'(OFF_MIN);

  logic [ACC_W:0]            sum_s;
  logic [ACC_W:0]            mean_s;
  logic signed [DIF_W-1:0]   diff_s;
  logic [ADC_W-1:0]          off_s;

  // Round-half-up mean, signed difference with headroom, then clamp.
  always_comb begin
    sum_s  = {1'b0, acc} + HALF;
    mean_s = sum_s >> LOG2_N;
    diff_s = MID_S - $signed({1'b0, mean_s});
    if (diff_s > MAX_S) begin
      off_s = ADC_W'(OFF_MAX);
      sat   = 1'b1;
    end else if (diff_s < MIN_S) begin
      off_s = ADC_W'(OFF_MIN);
      sat   = 1'b1;
    end else begin
      off_s = diff_s[ADC_W-1:0];
      sat   = 1'b0;
    end
    osc = sext_off(off_s);
  end

endmodule

// File: rtl/offset_cal_10b.sv
// Foreground offset-calibration engine: discards SETTLE valid samples, averages
// 2**LOG2_N samples and publishes the saturated correction on osc.
module offset_cal_10b
  import offset_cal_defs::*;
#(
  parameter int LOG2_N   = 6,
  parameter int SETTLE   = 4,
  parameter int MID_CODE = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cal_start,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_code,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_err,
  output logic [OSC_W-1:0] osc
);

  localparam int N     = 1 << LOG2_N;
  localparam int ACC_W = ADC_W + LOG2_N;
  localparam int SET_W = $clog2(SETTLE + 1);
  localparam int CNT_W = (SET_W > LOG2_N + 1) ? SET_W : LOG2_N + 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CNT_W-1:0] ACCUM_LAST  = CNT_W'(N - 1);

  cal_state_e        state_r;
  cal_state_e        state_nxt_s;
  logic [ACC_W-1:0]  acc_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              settle_last_s;
  logic              accum_last_s;

  logic [OSC_W-1:0]  osc_calc_s;
  logic              sat_s;

  logic              busy_nxt_s;
  logic              done_nxt_s;
  logic              err_nxt_s;
  logic [OSC_W-1:0]  osc_nxt_s;
  logic              busy_r;
  logic              done_r;
  logic              err_r;
  logic [OSC_W-1:0]  osc_r;

  assign settle_last_s = adc_valid && (cnt_r == SETTLE_LAST);
  assign accum_last_s  = adc_valid && (cnt_r == ACCUM_LAST);

  offset_cal_math #(
    .LOG2_N   (LOG2_N),
    .MID_CODE (MID_CODE)
  ) u_math (
    .acc (acc_r),
    .osc (osc_calc_s),
    .sat (sat_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cal_start) begin
          state_nxt_s = (SETTLE > 0) ? ST_SETTLE : ST_ACCUM;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_last_s) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_ACCUM: begin
        if (accum_last_s) begin
          state_nxt_s = ST_COMPUTE;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_COMPUTE: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Accumulator and shared settle/accumulate sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cal_start) begin
            acc_r <= '0;
            cnt_r <= '0;
          end
        end
        ST_SETTLE: begin
          if (adc_valid) begin
            cnt_r <= settle_last_s ? '0 : cnt_r + CNT_W'(1);
          end
        end
        ST_ACCUM: begin
          if (adc_valid) begin
            acc_r <= acc_r + ACC_W'(adc_code);
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          acc_r <= acc_r;
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Next values of the registered outputs; osc only moves on the COMPUTE exit.
  always_comb begin
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = 1'b0;
    err_nxt_s  = err_r;
    osc_nxt_s  = osc_r;
    case (state_r)
      ST_IDLE: begin
        if (cal_start) begin
          err_nxt_s = 1'b0;
        end else begin
          err_nxt_s = err_r;
        end
      end
      ST_COMPUTE: begin
        done_nxt_s = 1'b1;
        osc_nxt_s  = osc_calc_s;
        err_nxt_s  = err_r | sat_s;
      end
      default: begin
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      osc_r  <= '0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      err_r  <= err_nxt_s;
      osc_r  <= osc_nxt_s;
    end
  end

  assign cal_busy = busy_r;
  assign cal_done = done_r;
  assign cal_err  = err_r;
  assign osc      = osc_r;

endmodule
